// File: rtl/ddr_cmd_pkg.sv
// Shared constants, field widths and FSM encoding for the DDR command executor.
// Field widths match the command FIFO entry layout:
// {cmd_type, addr, burst_cnt, wt_data, wt_mask}.
package ddr_cmd_pkg;

  localparam int ADDR_W_DEF  = 27;
  localparam int DATA_W_DEF  = 128;
  localparam int MASK_W_DEF  = DATA_W_DEF / 8;
  localparam int BURST_W_DEF = 6;
  localparam int CMD_ENTRY_W = 1 + ADDR_W_DEF + BURST_W_DEF + DATA_W_DEF + MASK_W_DEF;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CMD  = 2'd1,
    WR_DATA = 2'd2,
    RD_CMD  = 2'd3
  } state_t;

endpackage

// File: rtl/ddr_rd_return.sv
// Read-return path: registers DDR read beats toward the response path (latency 1)
// and tracks how many read beats are still owed by the DDR IP.
// Ports: i_rdata/i_rdata_vld from the IP; i_issue/i_issue_burst when a read is
// accepted; i_req_burst/i_rsp_free for the credit compare; o_rsp_* forwarded beats;
// o_credit_ok = room for the candidate read; o_outstanding_nz for busy.
module ddr_rd_return #(
  parameter int DATA_W  = 128,
  parameter int BURST_W = 6,
  parameter int CNT_W   = BURST_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  i_rdata,
  input  logic               i_rdata_vld,
  input  logic               i_issue,
  input  logic [BURST_W-1:0] i_issue_burst,
  input  logic [BURST_W-1:0] i_req_burst,
  input  logic [CNT_W-1:0]   i_rsp_free,
  output logic               o_rsp_valid,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic               o_credit_ok,
  output logic               o_outstanding_nz
);

  localparam int CW = CNT_W + 1;

  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CW-1:0]    w_need;

  // One extra bit so burst+1+outstanding cannot wrap before the compare.
  assign w_need      = CW'(i_req_burst) + CW'(1) + CW'(r_outstanding);
  assign o_credit_ok = (CW'(i_rsp_free) >= w_need);
  assign o_outstanding_nz = (r_outstanding != '0);

  // Issue is added before the return beat is subtracted, so a same-cycle
  // issue and return nets to +beats-1; a stray beat with nothing owed stays at 0.
  always_comb begin
    w_cnt_next = r_outstanding;
    if (i_issue) begin
      w_cnt_next = w_cnt_next + CNT_W'(i_issue_burst) + CNT_W'(1);
    end
    if (i_rdata_vld && (w_cnt_next != '0)) begin
      w_cnt_next = w_cnt_next - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
    end else begin
      r_outstanding <= w_cnt_next;
      o_rsp_valid   <= i_rdata_vld;
      o_rsp_data    <= i_rdata;
    end
  end

endmodule

// File: rtl/ddr_cmd_exec.sv
// Pops command-FIFO entries and sequences them onto the DDR3 IP app interface;
// reads are issued only when the response FIFO has room for every owed beat.
// Ports: io_pop_* command FIFO pop side; app_* DDR IP command/write/read ports;
// io_rsp_* registered read beats plus downstream free count; busy status.
module ddr_cmd_exec
  import ddr_cmd_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MASK_W  = MASK_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_calib_complete,
  input  logic               io_pop_valid,
  output logic               io_pop_ready,
  input  logic               io_pop_cmd_type,
  input  logic [ADDR_W-1:0]  io_pop_addr,
  input  logic [BURST_W-1:0] io_pop_burst_cnt,
  input  logic [DATA_W-1:0]  io_pop_wt_data,
  input  logic [MASK_W-1:0]  io_pop_wt_mask,
  output logic [2:0]         app_cmd,
  output logic               app_cmd_en,
  input  logic               app_cmd_rdy,
  output logic [ADDR_W-1:0]  app_addr,
  output logic [BURST_W-1:0] app_burst_number,
  output logic [DATA_W-1:0]  app_wdata,
  output logic [MASK_W-1:0]  app_wdata_mask,
  output logic               app_wdata_en,
  output logic               app_wdata_end,
  input  logic               app_wdata_rdy,
  input  logic [DATA_W-1:0]  app_rdata,
  input  logic               app_rdata_valid,
  input  logic               app_rdata_end,
  output logic               io_rsp_valid,
  output logic [DATA_W-1:0]  io_rsp_data,
  input  logic [BURST_W:0]   io_rsp_free,
  output logic               busy
);

  state_t             r_state, w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_beat_cnt;
  logic               w_latch, w_beat_inc, w_beat_clr, w_rd_issue;
  logic               w_last_beat, w_credit_ok, w_outstanding_nz;
  logic               w_unused_rdata_end;

  // Read beats are counted individually, so the IP's end-of-burst flag adds nothing.
  assign w_unused_rdata_end = app_rdata_end;

  // beat_cnt never exceeds burst_cnt, so a 64-beat burst compares at 63 without wrapping.
  assign w_last_beat = (r_beat_cnt == r_burst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr  <= io_pop_addr;
        r_burst <= io_pop_burst_cnt;
      end
      if (w_beat_clr) begin
        r_beat_cnt <= '0;
      end else if (w_beat_inc) begin
        r_beat_cnt <= r_beat_cnt + BURST_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    app_cmd          = APP_CMD_WR;
    app_cmd_en       = 1'b0;
    app_addr         = '0;
    app_burst_number = '0;
    app_wdata        = '0;
    app_wdata_mask   = '0;
    app_wdata_en     = 1'b0;
    app_wdata_end    = 1'b0;
    io_pop_ready     = 1'b0;
    w_latch          = 1'b0;
    w_beat_inc       = 1'b0;
    w_beat_clr       = 1'b0;
    w_rd_issue       = 1'b0;
    case (r_state)
      IDLE: begin
        // Calibration only gates new commands; bursts in flight always finish.
        if (init_calib_complete && io_pop_valid) begin
          if (io_pop_cmd_type == CMD_WRITE) begin
            w_latch      = 1'b1;
            w_state_next = WR_CMD;
          end else if (w_credit_ok) begin
            w_latch      = 1'b1;
            w_state_next = RD_CMD;
          end
        end
      end
      WR_CMD: begin
        // Head entry stays in the FIFO: it also carries beat 0.
        app_cmd_en       = 1'b1;
        app_addr         = r_addr;
        app_burst_number = r_burst;
        if (app_cmd_rdy) begin
          w_state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        app_wdata_en   = io_pop_valid;
        app_wdata      = io_pop_wt_data;
        app_wdata_mask = io_pop_wt_mask;
        app_wdata_end  = io_pop_valid && w_last_beat;
        io_pop_ready   = app_wdata_rdy && io_pop_valid;
        if (app_wdata_rdy && io_pop_valid) begin
          if (w_last_beat) begin
            w_beat_clr   = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_beat_inc = 1'b1;
          end
        end
      end
      RD_CMD: begin
        app_cmd          = APP_CMD_RD;
        app_cmd_en       = 1'b1;
        app_addr         = r_addr;
        app_burst_number = r_burst;
        if (app_cmd_rdy) begin
          io_pop_ready = 1'b1;
          w_rd_issue   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  ddr_rd_return #(
    .DATA_W  (DATA_W),
    .BURST_W (BURST_W),
    .CNT_W   (BURST_W + 1)
  ) u_rd_return (
    .clk              (clk),
    .rst              (rst),
    .i_rdata          (app_rdata),
    .i_rdata_vld      (app_rdata_valid),
    .i_issue          (w_rd_issue),
    .i_issue_burst    (r_burst),
    .i_req_burst      (io_pop_burst_cnt),
    .i_rsp_free       (io_rsp_free),
    .o_rsp_valid      (io_rsp_valid),
    .o_rsp_data       (io_rsp_data),
    .o_credit_ok      (w_credit_ok),
    .o_outstanding_nz (w_outstanding_nz)
  );

  assign busy = (r_state != IDLE) || w_outstanding_nz;

endmodule

// File: tb/tb_ddr_cmd_exec.sv
// Scoreboard bench for ddr_cmd_exec: directed command sequences, expected
// DDR commands / write beats / response beats queued at stimulus time and
// compared by an independent monitor on the falling edge.
module tb_ddr_cmd_exec;
  import ddr_cmd_pkg::*;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int BW = 6;

  localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] W2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_0000;
  localparam logic [DW-1:0] R3 = 128'h5EED_0000_0000_0000_0000_0000_0000_0100;
  localparam logic [DW-1:0] R4 = 128'hC0DE_0000_0000_0000_0000_0000_0000_0200;
  localparam logic [DW-1:0] D5 = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [DW-1:0] B6 = 128'hB0B0_0000_0000_0000_0000_0000_0000_0600;
  localparam logic [DW-1:0] R6 = 128'h7777_0000_0000_0000_0000_0000_0000_0700;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_calib_complete;
  logic          io_pop_valid, io_pop_ready, io_pop_cmd_type;
  logic [AW-1:0] io_pop_addr;
  logic [BW-1:0] io_pop_burst_cnt;
  logic [DW-1:0] io_pop_wt_data;
  logic [MW-1:0] io_pop_wt_mask;
  logic [2:0]    app_cmd;
  logic          app_cmd_en, app_cmd_rdy;
  logic [AW-1:0] app_addr;
  logic [BW-1:0] app_burst_number;
  logic [DW-1:0] app_wdata;
  logic [MW-1:0] app_wdata_mask;
  logic          app_wdata_en, app_wdata_end, app_wdata_rdy;
  logic [DW-1:0] app_rdata;
  logic          app_rdata_valid, app_rdata_end;
  logic          io_rsp_valid;
  logic [DW-1:0] io_rsp_data;
  logic [BW:0]   io_rsp_free;
  logic          busy;

  ddr_cmd_exec dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .io_pop_valid(io_pop_valid), .io_pop_ready(io_pop_ready),
    .io_pop_cmd_type(io_pop_cmd_type), .io_pop_addr(io_pop_addr),
    .io_pop_burst_cnt(io_pop_burst_cnt), .io_pop_wt_data(io_pop_wt_data),
    .io_pop_wt_mask(io_pop_wt_mask), .app_cmd(app_cmd), .app_cmd_en(app_cmd_en),
    .app_cmd_rdy(app_cmd_rdy), .app_addr(app_addr), .app_burst_number(app_burst_number),
    .app_wdata(app_wdata), .app_wdata_mask(app_wdata_mask), .app_wdata_en(app_wdata_en),
    .app_wdata_end(app_wdata_end), .app_wdata_rdy(app_wdata_rdy), .app_rdata(app_rdata),
    .app_rdata_valid(app_rdata_valid), .app_rdata_end(app_rdata_end),
    .io_rsp_valid(io_rsp_valid), .io_rsp_data(io_rsp_data), .io_rsp_free(io_rsp_free),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cmd_type;
    logic [AW-1:0] addr;
    logic [BW-1:0] burst;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } ent_t;

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [BW-1:0] burst;
  } ecmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          last;
  } ewr_t;

  ent_t          fifo_q[$];
  ecmd_t         exp_cmd[$];
  ewr_t          exp_wr[$];
  logic [DW-1:0] exp_rsp[$];

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int cmd_cyc = 0;
  int rsp_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic any_out();
    return (|app_cmd) | app_cmd_en | (|app_addr) | (|app_burst_number) | (|app_wdata) |
           (|app_wdata_mask) | app_wdata_en | app_wdata_end | io_pop_ready |
           io_rsp_valid | (|io_rsp_data) | busy;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ent(input logic t, input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    ent_t e;
    e.cmd_type = t; e.addr = a; e.burst = b; e.data = d; e.mask = m;
    fifo_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || busy) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle_timeout"}, DW'(k >= lim), DW'(0));
    cyc(1);
  endtask

  // Returns on the falling edge of the cycle in which the command is accepted.
  task automatic wait_cmd_acc(input string nm, input int lim);
    int k;
    k = 0;
    while (!(app_cmd_en && app_cmd_rdy) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_cmd_timeout"}, DW'(k >= lim), DW'(0));
  endtask

  task automatic send_rbeats(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      app_rdata_valid = 1'b1;
      app_rdata       = base + DW'(i);
      app_rdata_end   = (i == n - 1);
      exp_rsp.push_back(base + DW'(i));
      cyc(1);
    end
    app_rdata_valid = 1'b0;
    app_rdata_end   = 1'b0;
    app_rdata       = '0;
  endtask

  // Command FIFO model: head shown on io_pop_*, popped on a sampled handshake.
  initial begin : fifo_drv
    logic take;
    io_pop_valid = 1'b0; io_pop_cmd_type = 1'b0; io_pop_addr = '0;
    io_pop_burst_cnt = '0; io_pop_wt_data = '0; io_pop_wt_mask = '0;
    forever begin
      @(negedge clk);
      take = io_pop_valid && io_pop_ready;
      @(posedge clk);
      #2;
      if (take && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      if (fifo_q.size() > 0) begin
        io_pop_valid     = 1'b1;
        io_pop_cmd_type  = fifo_q[0].cmd_type;
        io_pop_addr      = fifo_q[0].addr;
        io_pop_burst_cnt = fifo_q[0].burst;
        io_pop_wt_data   = fifo_q[0].data;
        io_pop_wt_mask   = fifo_q[0].mask;
      end else begin
        io_pop_valid = 1'b0;
      end
    end
  end

  initial begin : mon
    ecmd_t         ec;
    ewr_t          ew;
    logic [DW-1:0] er;
    forever begin
      @(negedge clk);
      if (app_cmd_en) cmd_cyc++;
      if (app_cmd_en || app_wdata_en)
        chk("cmd_wdata_exclusive", DW'(app_cmd_en && app_wdata_en), DW'(0));
      if (app_cmd_en && app_cmd_rdy) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cmd_unexpected: got addr %0h expected no command", app_addr);
        end else begin
          ec = exp_cmd.pop_front();
          chk("cmd_type", DW'(app_cmd), DW'(ec.cmd));
          chk("cmd_addr", DW'(app_addr), DW'(ec.addr));
          chk("cmd_burst", DW'(app_burst_number), DW'(ec.burst));
        end
      end
      if (app_wdata_en && app_wdata_rdy) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wbeat_unexpected: got %0h expected no beat", app_wdata);
        end else begin
          ew = exp_wr.pop_front();
          chk("wdata", app_wdata, ew.data);
          chk("wmask", DW'(app_wdata_mask), DW'(ew.mask));
          chk("wend", DW'(app_wdata_end), DW'(ew.last));
        end
      end
      if (io_rsp_valid) begin
        rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_unexpected: got %0h expected no beat", io_rsp_data);
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_data", io_rsp_data, er);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   k;
    logic flag;
    rst = 1'b1; init_calib_complete = 1'b1; app_cmd_rdy = 1'b1; app_wdata_rdy = 1'b1;
    app_rdata = '0; app_rdata_valid = 1'b0; app_rdata_end = 1'b0; io_rsp_free = 7'd64;
    cyc(3);
    chk("reset_outputs", DW'(any_out()), DW'(0));
    rst = 1'b0;
    cyc(2);
    chk("idle_busy", DW'(busy), DW'(0));

    // Single-beat write
    pop_cnt = 0; cmd_cyc = 0;
    exp_cmd.push_back('{APP_CMD_WR, 27'h100, 6'd0});
    exp_wr.push_back('{D0, 16'h0000, 1'b1});
    push_ent(1'b1, 27'h100, 6'd0, D0, 16'h0000);
    wait_idle("t1", 50);
    chk("t1_pops", DW'(pop_cnt), DW'(1));
    chk("t1_cmd_cycles", DW'(cmd_cyc), DW'(1));
    chk("t1_busy", DW'(busy), DW'(0));

    // 4-beat write, command stalled 3 cycles, wdata_rdy toggling
    pop_cnt = 0; cmd_cyc = 0; app_cmd_rdy = 1'b0;
    exp_cmd.push_back('{APP_CMD_WR, 27'h340, 6'd3});
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{W2 + DW'(i), MW'(16'h1111 * (i + 1)), (i == 3)});
      push_ent((i == 0), (i == 0) ? 27'h340 : 27'h7FF_FFFF, (i == 0) ? 6'd3 : 6'h2A,
               W2 + DW'(i), MW'(16'h1111 * (i + 1)));
    end
    k = 0;
    while (!app_cmd_en && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("t2_cmd_seen", DW'(app_cmd_en), DW'(1));
    repeat (3) @(posedge clk);
    #1;
    app_cmd_rdy = 1'b1;
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || busy); i++) begin
      app_wdata_rdy = ~app_wdata_rdy;
      cyc(1);
    end
    app_wdata_rdy = 1'b1;
    wait_idle("t2", 30);
    chk("t2_pops", DW'(pop_cnt), DW'(4));
    chk("t2_cmd_cycles", DW'(cmd_cyc), DW'(4));

    // 8-beat read with full credit
    pop_cnt = 0; rsp_cnt = 0;
    exp_cmd.push_back('{APP_CMD_RD, 27'h2000, 6'd7});
    push_ent(1'b0, 27'h2000, 6'd7, '1, 16'hFFFF);
    wait_cmd_acc("t3", 30);
    @(posedge clk);
    #1;
    chk("t3_busy_after_issue", DW'(busy), DW'(1));
    send_rbeats(7, R3);
    chk("t3_busy_one_left", DW'(busy), DW'(1));
    send_rbeats(1, R3 + DW'(7));
    chk("t3_busy_drained", DW'(busy), DW'(0));
    cyc(2);
    chk("t3_pops", DW'(pop_cnt), DW'(1));
    chk("t3_rsp_beats", DW'(rsp_cnt), DW'(8));

    // Credit stall: 4 free < 8 needed, then exactly 8
    pop_cnt = 0; io_rsp_free = 7'd4; flag = 1'b0;
    exp_cmd.push_back('{APP_CMD_RD, 27'h3000, 6'd7});
    push_ent(1'b0, 27'h3000, 6'd7, '0, 16'h0000);
    repeat (6) begin
      @(negedge clk);
      if (app_cmd_en || io_pop_ready) flag = 1'b1;
    end
    chk("t4_stalled", DW'(flag), DW'(0));
    chk("t4_no_pop", DW'(pop_cnt), DW'(0));
    @(posedge clk);
    #1;
    io_rsp_free = 7'd8;
    @(posedge clk);
    @(negedge clk);
    chk("t4_issue_next_cycle", DW'(app_cmd_en), DW'(1));
    cyc(1);
    send_rbeats(8, R4);
    wait_idle("t4", 20);
    chk("t4_pops", DW'(pop_cnt), DW'(1));
    io_rsp_free = 7'd64;

    // Calibration gating
    pop_cnt = 0; init_calib_complete = 1'b0; flag = 1'b0;
    exp_cmd.push_back('{APP_CMD_WR, 27'h500, 6'd0});
    exp_wr.push_back('{D5, 16'h00F0, 1'b1});
    push_ent(1'b1, 27'h500, 6'd0, D5, 16'h00F0);
    repeat (8) begin
      @(negedge clk);
      if (app_cmd_en || app_wdata_en || io_pop_ready || busy) flag = 1'b1;
    end
    chk("t5_calib_gated", DW'(flag), DW'(0));
    cyc(1);
    init_calib_complete = 1'b1;
    wait_idle("t5", 30);
    chk("t5_pops", DW'(pop_cnt), DW'(1));

    // Async reset while holding in WR_DATA
    app_wdata_rdy = 1'b0;
    exp_cmd.push_back('{APP_CMD_WR, 27'h600, 6'd3});
    push_ent(1'b1, 27'h600, 6'd3, D5, 16'h0000);
    push_ent(1'b1, 27'h600, 6'd3, D5 + DW'(1), 16'h0000);
    wait_cmd_acc("t5r", 30);
    @(posedge clk);
    #1;
    chk("t5r_in_wdata", DW'(app_wdata_en), DW'(1));
    rst = 1'b1;
    fifo_q.delete();
    io_pop_valid = 1'b0;
    #1;
    chk("t5r_async_reset_outputs", DW'(any_out()), DW'(0));
    cyc(2);
    rst = 1'b0;
    app_wdata_rdy = 1'b1;
    cyc(3);
    chk("t5r_idle_after_release", DW'(any_out()), DW'(0));

    // Back-to-back read / write / read
    pop_cnt = 0; rsp_cnt = 0;
    exp_cmd.push_back('{APP_CMD_RD, 27'h4000, 6'd1});
    exp_cmd.push_back('{APP_CMD_WR, 27'h4100, 6'd1});
    exp_cmd.push_back('{APP_CMD_RD, 27'h4200, 6'd0});
    exp_wr.push_back('{B6, 16'h0003, 1'b0});
    exp_wr.push_back('{B6 + DW'(1), 16'hC000, 1'b1});
    push_ent(1'b0, 27'h4000, 6'd1, '0, 16'h0000);
    push_ent(1'b1, 27'h4100, 6'd1, B6, 16'h0003);
    push_ent(1'b0, 27'h0, 6'd0, B6 + DW'(1), 16'hC000);
    push_ent(1'b0, 27'h4200, 6'd0, '0, 16'h0000);
    k = 0;
    while (fifo_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_fifo_drain_timeout", DW'(k >= 100), DW'(0));
    cyc(2);
    chk("t6_busy_reads_owed", DW'(busy), DW'(1));
    send_rbeats(3, R6);
    wait_idle("t6", 20);
    cyc(2);
    chk("t6_rsp_beats", DW'(rsp_cnt), DW'(3));
    chk("t6_pops", DW'(pop_cnt), DW'(4));

    chk("left_cmd", DW'(exp_cmd.size()), DW'(0));
    chk("left_wbeats", DW'(exp_wr.size()), DW'(0));
    chk("left_rsp", DW'(exp_rsp.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_exec.md
Name: ddr_cmd_exec

Overview:
- Consumer end of the clock-domain-crossing DDR command FIFO, in the DDR controller user-clock domain.
- Pops 178-bit command entries (cmd_type, addr, burst_cnt, wt_data, wt_mask) and sequences them onto the Gowin DDR3 IP user interface.
- Collects read-return beats and forwards them to the response path.
- Sole owner of the DDR3 IP app-side command and write-data ports.

Parameters:
- ADDR_W, 27, command/DDR app address width
- DATA_W, 128, data beat width
- MASK_W, 16, write byte-mask width (DATA_W/8)
- BURST_W, 6, burst count width; beats = burst_cnt + 1 (1..64)

Ports:
- clk  in  1  DDR IP user clock (pop side of command FIFO)
- rst  in  1  asynchronous, active-high reset
- init_calib_complete  in  1  DDR IP calibration done
- io_pop_valid  in  1  FIFO entry available
- io_pop_ready  out  1  entry consumed this cycle
- io_pop_cmd_type  in  1  0=read, 1=write
- io_pop_addr  in  ADDR_W  beat-aligned start address
- io_pop_burst_cnt  in  BURST_W  beats-1
- io_pop_wt_data  in  DATA_W  write beat
- io_pop_wt_mask  in  MASK_W  write mask, 1=byte masked
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_cmd_en  out  1  command strobe
- app_cmd_rdy  in  1  IP accepts command
- app_addr  out  ADDR_W  command address
- app_burst_number  out  BURST_W  beats-1
- app_wdata  out  DATA_W  write data
- app_wdata_mask  out  MASK_W  write mask
- app_wdata_en  out  1  write beat strobe
- app_wdata_end  out  1  last write beat of burst
- app_wdata_rdy  in  1  IP accepts write beat
- app_rdata  in  DATA_W  read beat
- app_rdata_valid  in  1  read beat valid (no backpressure)
- app_rdata_end  in  1  last read beat
- io_rsp_valid  out  1  response beat valid (no ready)
- io_rsp_data  out  DATA_W  response beat
- io_rsp_free  in  7  free entries in downstream response FIFO (0..64)
- busy  out  1  state != IDLE or outstanding read beats != 0

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; app_cmd=3'b000; rd_outstanding=0; beat_cnt=0.
- Write burst framing:
  - First entry carries cmd, addr, burst_cnt and beat 0.
  - The next burst_cnt entries are data-only; their cmd_type/addr/burst_cnt are ignored.
- States:
  - IDLE:
    - Wait for init_calib_complete && io_pop_valid.
    - Write: latch addr/burst_cnt, go WR_CMD.
    - Read: go RD_CMD only if io_rsp_free >= burst_cnt+1+rd_outstanding; otherwise stall with io_pop_ready=0.
  - WR_CMD:
    - app_cmd_en=1, app_cmd=000, app_addr/app_burst_number from latch; held until app_cmd_rdy=1, then go WR_DATA.
    - Head entry is not popped here.
  - WR_DATA:
    - app_wdata_en = io_pop_valid; app_wdata/mask driven straight from the pop entry.
    - io_pop_ready = app_wdata_rdy && io_pop_valid.
    - Each accepted beat increments beat_cnt.
    - app_wdata_end=1 when beat_cnt==latched burst_cnt; on that beat's acceptance go IDLE with beat_cnt cleared.
  - RD_CMD:
    - app_cmd_en=1, app_cmd=001, held until app_cmd_rdy.
    - On that same cycle: io_pop_ready=1 (pop the read entry), rd_outstanding += burst_cnt+1, go IDLE.
- Read return:
  - Independent of the FSM.
  - io_rsp_valid/io_rsp_data are app_rdata_valid/app_rdata registered once (latency 1).
  - rd_outstanding decrements by 1 per valid beat.
  - Same-cycle issue and return: rd_outstanding = rd_outstanding + beats − 1.
- Credit rule: read responses can never overflow the downstream FIFO, because each read is issued only when io_rsp_free >= burst_cnt+1+rd_outstanding.
- Ordering: strictly in order; the next command is not popped until the current write's last beat is accepted.
- app_cmd_en and app_wdata_en are never both 1 in the same cycle.
- Width rule: beat_cnt is BURST_W bits. burst_cnt=63 gives 64 beats with no wrap before the compare.
- init_calib_complete falling mid-burst: the current burst completes; new commands are blocked.
- io_pop_valid low mid-write: app_wdata_en=0; the FSM holds in WR_DATA.
- Unexpected app_rdata_valid with rd_outstanding=0: the beat is still forwarded; the counter saturates at 0.
- busy: combinational function of state and rd_outstanding.

Decomposition:
- Package ddr_cmd_pkg holds:
  - Constants CMD_WRITE=1, CMD_READ=0, APP_CMD_WR=3'b000, APP_CMD_RD=3'b001.
  - State encoding IDLE/WR_CMD/WR_DATA/RD_CMD.
  - Field widths shared with cmd_fifo.
- One sub-module, ddr_rd_return, contains the registered rdata forwarding and the rd_outstanding counter with credit compare output.

Test Plan:
- Single write: entry {wr, addr=0x100, burst_cnt=0, data=D0, mask=0}, rdy always 1 -> cmd_en one cycle with cmd=000, addr=0x100, burst_number=0; then one wdata_en with wdata_end=1 and data D0; pop_ready one cycle; busy returns 0.
- 4-beat write with backpressure:
  - Stimulus: burst_cnt=3; app_cmd_rdy low for 3 cycles; app_wdata_rdy toggling.
  - Response: cmd_en held 4 cycles; exactly 4 pops; wdata_end only on beat 3; mask passed per beat.
- Read burst: {rd, addr=0x2000, burst_cnt=7}, io_rsp_free=64 -> cmd_en with cmd=001, burst_number=7; pop on acceptance; 8 rdata_valid beats produce 8 rsp_valid beats one cycle later; rd_outstanding goes 8->0.
- Credit stall: io_rsp_free=4 with a pending read burst_cnt=7 -> no cmd_en and io_pop_ready=0; raising io_rsp_free to 8 issues the read the next cycle.
- Calibration gating and reset:
  - init_calib_complete=0 with a pending entry -> no activity.
  - Assert rst mid-WR_DATA -> all outputs 0 asynchronously; state IDLE after release.
- Back-to-back mixed: read burst_cnt=1, write burst_cnt=1, read burst_cnt=0 -> commands issued in order; app_cmd_en and app_wdata_en never both high; 3 response beats returned.
